wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Parametrised register-file write-back stage for the MIPS32 core. It selects the committing pipeline result from `NUM_SRC` packed sources (ALU, load data, and others). It also buffers out-of-band results from long-latency side units (e.g. the SAD minimum engine) in an in-order FIFO. Buffered results are drained into write-back slots the pipeline leaves idle. The block drives a single registered write port into the register file and exposes pending-destination lookup for the hazard unit.

## Interface
Parameters:
- `DATA_W`, 32, data width
- `REG_AW`, 5, register address width
- `NUM_SRC`, 3, pipeline result sources; `SEL_W = max(1, clog2(NUM_SRC))`
- `FIFO_DEPTH`, 4, side-result buffer entries (power of two, ≥2); `CNT_W = clog2(FIFO_DEPTH+1)`

Ports:
- `Clk` in 1: rising-edge clock
- `Rst_n` in 1: asynchronous active-low reset
- `MEM_WB_Valid` in 1: an instruction occupies MEM/WB
- `MEM_WB_RegWrite` in 1: that instruction writes the register file
- `MEM_WB_WriteReg` in REG_AW: destination register
- `MEM_WB_SrcSel` in SEL_W: source index
- `MEM_WB_SrcData` in NUM_SRC*DATA_W: packed sources, source i at bits [i*DATA_W +: DATA_W]
- `Side_Valid` in 1: side result offered
- `Side_Ready` out 1: side result accepted when Valid&&Ready at the clock edge
- `Side_Reg` in REG_AW, `Side_Data` in DATA_W: side destination and data
- `Query_Reg` in REG_AW: hazard-unit lookup address
- `Query_Hit` out 1: combinational; a live FIFO entry targets `Query_Reg` (always 0 for register 0)
- `Side_Count` out CNT_W: FIFO occupancy
- `WB_RegWrite` out 1, `WB_WriteReg` out REG_AW, `WB_WriteData` out DATA_W: registered write port

## Operation
- Pipeline commit (PC) = `MEM_WB_Valid && MEM_WB_RegWrite && MEM_WB_WriteReg != 0`.
- On PC, the write port loads `{1, MEM_WB_WriteReg, source[MEM_WB_SrcSel]}`.
- A `MEM_WB_SrcSel >= NUM_SRC` selects source 0.
- PC has absolute priority over the FIFO.
- Side accept: `Side_Ready = (Side_Count != FIFO_DEPTH)`. It is a function of registered count only; a dequeue in the same cycle does not free a slot early.
- Accepted entries with `Side_Reg == 0` are discarded and never enqueued.
- FIFO entry = {live, reg, data}, strictly in order.
- Squash: on PC, every live FIFO entry with reg == `MEM_WB_WriteReg` is cleared to dead in the same cycle, because the pipeline write is the newer value.
  - A side entry accepted in that same cycle to the same register is enqueued live. The side result is defined as newer.
- Drain: if no PC and the head is live, the write port loads the head and pops it.
- Dead head entries are popped in any cycle, including PC cycles, without a write. One pop per cycle at most.
- Idle cycle (no PC, no live head): `WB_RegWrite` = 0. `WB_WriteReg` and `WB_WriteData` hold their previous values.
- Enqueue and pop may occur in the same cycle; count is unchanged and pointers wrap modulo `FIFO_DEPTH`.
- `Query_Hit` includes live entries only, not entries being accepted this cycle.

## Timing
- Reset (async, `Rst_n`=0): `WB_RegWrite`=0, `WB_WriteReg`=0, `WB_WriteData`=0, `Side_Count`=0, all entries dead. This gives `Side_Ready`=1 and `Query_Hit`=0 while reset is held.
- Reset mid-operation flushes all pending side results with no write.
- Pipeline latency: inputs sampled at edge k; the write port is valid for the cycle after edge k (1 cycle).
- Side latency: accepted at edge k, written at edge k+1 at the earliest. There is no bypass around the FIFO.
- Side results are delayed one cycle per intervening PC cycle.
- A full FIFO with continuous PC holds `Side_Ready`=0 indefinitely. Upstream side units must stall.

## Test plan
- Source select: NUM_SRC=3, commit reg 8 with SrcSel=2 and source2=0xCAFEF00D → next cycle WB_RegWrite=1, WB_WriteReg=8, WB_WriteData=0xCAFEF00D. SrcSel=3 → source0 value written. WriteReg=0 → WB_RegWrite=0.
- Side drain: idle pipeline, side {reg 5, 0x1234} accepted at edge k → Side_Count=1 after edge k, and Query_Reg=5 gives Query_Hit=1. Reg 5 = 0x1234 is written at edge k+1, then Side_Count=0.
- Priority/backpressure: FIFO_DEPTH=4, continuous PC, offer 5 side results → Side_Ready falls after 4 accepts, Side_Count=4. When PC stops, 4 writes drain in accept order on 4 consecutive cycles.
- Squash: FIFO holds live reg 9 and reg 10, then PC to reg 9 → Query_Reg=9 gives Hit=0. The following drain writes only reg 10; the dead reg-9 entry pops with no write.
- Simultaneous accept+pop at full-minus-one with pointer wrap over 3×DEPTH transactions → order and data intact, count never exceeds DEPTH.
- Assert Rst_n=0 with 3 pending entries and WB_RegWrite=1 → all outputs are 0 immediately. After release, no stale write occurs.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Register-file write-back stage. Selects the committing MEM/WB result from
// NUM_SRC packed sources and drives one registered write port. Results from
// long-latency side units are queued in an in-order FIFO. They are written only
// in cycles the pipeline leaves free.
//
// Ports:
//   Clk, Rst_n           clock, asynchronous active-low reset
//   MEM_WB_*             committing instruction: valid, regwrite, dest, source select, sources
//   Side_Valid/Ready     side-result handshake; Side_Reg/Side_Data carry the result
//   Query_Reg/Query_Hit  hazard lookup: a live queued entry targets Query_Reg
//   Side_Count           FIFO occupancy
//   WB_*                 registered register-file write port
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      MEM_WB_Valid,
    input  logic                      MEM_WB_RegWrite,
    input  logic [REG_AW-1:0]         MEM_WB_WriteReg,
    input  logic [SEL_W-1:0]          MEM_WB_SrcSel,
    input  logic [NUM_SRC*DATA_W-1:0] MEM_WB_SrcData,
    input  logic                      Side_Valid,
    output logic                      Side_Ready,
    input  logic [REG_AW-1:0]         Side_Reg,
    input  logic [DATA_W-1:0]         Side_Data,
    input  logic [REG_AW-1:0]         Query_Reg,
    output logic                      Query_Hit,
    output logic [CNT_W-1:0]          Side_Count,
    output logic                      WB_RegWrite,
    output logic [REG_AW-1:0]         WB_WriteReg,
    output logic [DATA_W-1:0]         WB_WriteData
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic              entLive [FIFO_DEPTH];
    logic [REG_AW-1:0] entReg  [FIFO_DEPTH];
    logic [DATA_W-1:0] entData [FIFO_DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  countNext;

    logic              pipeCommit;
    logic [DATA_W-1:0] pipeData;
    logic              headLive;
    logic              drain;
    logic              pop;
    logic              enq;

    assign pipeCommit = MEM_WB_Valid && MEM_WB_RegWrite && (MEM_WB_WriteReg != '0);

    // Out-of-range selects fall back to source 0.
    always_comb begin
        pipeData = MEM_WB_SrcData[DATA_W-1:0];
        for (int unsigned i = 1; i < NUM_SRC; i++) begin
            if (MEM_WB_SrcSel == SEL_W'(i)) begin
                pipeData = MEM_WB_SrcData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Slots outside the occupied range are always dead, so no count qualifier is needed.
    assign headLive = entLive[headPtr];
    assign drain    = !pipeCommit && headLive;
    // A dead head is retired even while the pipeline owns the write port.
    assign pop      = (count != '0) && !(headLive && pipeCommit);

    // Readiness comes from the registered count only; a same-cycle pop does not free a slot.
    assign Side_Ready = (count != FULL_CNT);
    // Writes to r0 are accepted but dropped.
    assign enq        = Side_Valid && Side_Ready && (Side_Reg != '0);
    assign countNext  = count + CNT_W'(enq) - CNT_W'(pop);
    assign Side_Count = count;

    always_comb begin
        Query_Hit = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (entLive[i] && (entReg[i] == Query_Reg)) begin
                Query_Hit = 1'b1;
            end
        end
        if (Query_Reg == '0) begin
            Query_Hit = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                entLive[i] <= 1'b0;
                entReg[i]  <= '0;
                entData[i] <= '0;
            end
            headPtr      <= '0;
            tailPtr      <= '0;
            count        <= '0;
            WB_RegWrite  <= 1'b0;
            WB_WriteReg  <= '0;
            WB_WriteData <= '0;
        end else begin
            // The pipeline write is newer than any queued result for the same register.
            if (pipeCommit) begin
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    if (entReg[i] == MEM_WB_WriteReg) begin
                        entLive[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                entLive[headPtr] <= 1'b0;
                headPtr          <= headPtr + PTR_W'(1);
            end
            // Placed after the squash so a same-cycle side result to that register stays live.
            if (enq) begin
                entLive[tailPtr] <= 1'b1;
                entReg[tailPtr]  <= Side_Reg;
                entData[tailPtr] <= Side_Data;
                tailPtr          <= tailPtr + PTR_W'(1);
            end
            count <= countNext;

            if (pipeCommit) begin
                WB_RegWrite  <= 1'b1;
                WB_WriteReg  <= MEM_WB_WriteReg;
                WB_WriteData <= pipeData;
            end else if (drain) begin
                WB_RegWrite  <= 1'b1;
                WB_WriteReg  <= entReg[headPtr];
                WB_WriteData <= entData[headPtr];
            end else begin
                WB_RegWrite  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned NUM_SRC    = 3;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        MEM_WB_Valid = 1'b0;
    logic        MEM_WB_RegWrite = 1'b0;
    logic [4:0]  MEM_WB_WriteReg = '0;
    logic [1:0]  MEM_WB_SrcSel = '0;
    logic [95:0] MEM_WB_SrcData = '0;
    logic        Side_Valid = 1'b0;
    logic        Side_Ready;
    logic [4:0]  Side_Reg = '0;
    logic [31:0] Side_Data = '0;
    logic [4:0]  Query_Reg = '0;
    logic        Query_Hit;
    logic [2:0]  Side_Count;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;

    wb_port_arbiter #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .NUM_SRC    (NUM_SRC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .MEM_WB_Valid    (MEM_WB_Valid),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .MEM_WB_WriteReg (MEM_WB_WriteReg),
        .MEM_WB_SrcSel   (MEM_WB_SrcSel),
        .MEM_WB_SrcData  (MEM_WB_SrcData),
        .Side_Valid      (Side_Valid),
        .Side_Ready      (Side_Ready),
        .Side_Reg        (Side_Reg),
        .Side_Data       (Side_Data),
        .Query_Reg       (Query_Reg),
        .Query_Hit       (Query_Hit),
        .Side_Count      (Side_Count),
        .WB_RegWrite     (WB_RegWrite),
        .WB_WriteReg     (WB_WriteReg),
        .WB_WriteData    (WB_WriteData)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        sideQ[$];
    ent_t        pipeQ[$];
    int          nChecks = 0;
    int          nPass = 0;
    int          nFail = 0;
    logic [4:0]  lastReg = '0;
    logic [31:0] lastData = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the scoreboard, clock, then check the write port.
    task automatic step(input bit pcV, input bit rw, input logic [4:0] wreg,
                        input logic [1:0] sel, input logic [95:0] src, input bit sv,
                        input logic [4:0] sreg, input logic [31:0] sdata, input bit expAcc);
        bit          pcNow;
        ent_t        e;
        logic [31:0] pd;
        MEM_WB_Valid    = pcV;
        MEM_WB_RegWrite = rw;
        MEM_WB_WriteReg = wreg;
        MEM_WB_SrcSel   = sel;
        MEM_WB_SrcData  = src;
        Side_Valid      = sv;
        Side_Reg        = sreg;
        Side_Data       = sdata;
        #1;
        pcNow = pcV && rw && (wreg != 5'd0);
        if (sv) check("side_ready", 32'(Side_Ready), 32'(expAcc));
        if (pcNow) begin
            pd = (sel == 2'd1) ? src[63:32] : (sel == 2'd2) ? src[95:64] : src[31:0];
            pipeQ.push_back('{r: wreg, d: pd});
            for (int i = sideQ.size() - 1; i >= 0; i--) begin
                if (sideQ[i].r == wreg) sideQ.delete(i);
            end
        end
        if (sv && expAcc && (sreg != 5'd0)) sideQ.push_back('{r: sreg, d: sdata});
        @(posedge Clk);
        #1;
        MEM_WB_Valid = 1'b0;
        MEM_WB_RegWrite = 1'b0;
        Side_Valid = 1'b0;
        if (pcNow) begin
            e = pipeQ.pop_front();
            check("pc_we", 32'(WB_RegWrite), 32'd1);
            check("pc_reg", 32'(WB_WriteReg), 32'(e.r));
            check("pc_data", WB_WriteData, e.d);
            lastReg  = e.r;
            lastData = e.d;
        end else if (WB_RegWrite) begin
            if (sideQ.size() == 0) begin
                check("stale_write", 32'(WB_RegWrite), 32'd0);
            end else begin
                e = sideQ.pop_front();
                check("side_reg", 32'(WB_WriteReg), 32'(e.r));
                check("side_data", WB_WriteData, e.d);
                lastReg  = e.r;
                lastData = e.d;
            end
        end else begin
            check("hold_reg", 32'(WB_WriteReg), 32'(lastReg));
            check("hold_data", WB_WriteData, lastData);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 2'd0, 96'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic query(input string tag, input logic [4:0] r, input bit exp);
        Query_Reg = r;
        #1;
        check(tag, 32'(Query_Hit), 32'(exp));
    endtask

    initial begin
        // Reset state
        #2 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Query_Reg = 5'd5;
        #1;
        check("rst_we", 32'(WB_RegWrite), 32'd0);
        check("rst_reg", 32'(WB_WriteReg), 32'd0);
        check("rst_data", WB_WriteData, 32'd0);
        check("rst_count", 32'(Side_Count), 32'd0);
        check("rst_ready", 32'(Side_Ready), 32'd1);
        check("rst_hit", 32'(Query_Hit), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Source select
        step(1'b1, 1'b1, 5'd8, 2'd2, {32'hCAFEF00D, 32'h11111111, 32'hAAAA0000},
             1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 5'd7, 2'd3, {32'hCAFEF00D, 32'h11111111, 32'hAAAA0000},
             1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 5'd31, 2'd1, {32'hCAFEF00D, 32'h11111111, 32'hAAAA0000},
             1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 5'd0, 2'd2, {32'hCAFEF00D, 32'h11111111, 32'hAAAA0000},
             1'b0, 5'd0, 32'd0, 1'b0);
        check("r0_no_write", 32'(WB_RegWrite), 32'd0);
        step(1'b1, 1'b0, 5'd6, 2'd0, {32'h1, 32'h2, 32'h3}, 1'b0, 5'd0, 32'd0, 1'b0);
        check("nowrite_no_write", 32'(WB_RegWrite), 32'd0);

        // Side drain through an idle pipeline
        step(1'b0, 1'b0, 5'd0, 2'd0, 96'd0, 1'b1, 5'd5, 32'h1234, 1'b1);
        check("drain_count1", 32'(Side_Count), 32'd1);
        check("drain_no_bypass", 32'(WB_RegWrite), 32'd0);
        query("drain_hit5", 5'd5, 1'b1);
        query("hit_r0", 5'd0, 1'b0);
        idle();
        check("drain_we", 32'(WB_RegWrite), 32'd1);
        check("drain_count0", 32'(Side_Count), 32'd0);
        query("drain_hit5_gone", 5'd5, 1'b0);

        // r0 side results are dropped
        step(1'b0, 1'b0, 5'd0, 2'd0, 96'd0, 1'b1, 5'd0, 32'hDEAD, 1'b1);
        check("r0_side_count", 32'(Side_Count), 32'd0);
        idle();
        check("r0_side_no_write", 32'(WB_RegWrite), 32'd0);

        // Priority and backpressure
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 5'(20 + i), 2'd0, {64'd0, 32'h7000 + 32'(i)},
                 1'b1, 5'(11 + i), 32'hB000 + 32'(i), (i < 4));
        end
        check("bp_count_full", 32'(Side_Count), 32'd4);
        check("bp_ready_low", 32'(Side_Ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("bp_drain_we", 32'(WB_RegWrite), 32'd1);
        end
        check("bp_count0", 32'(Side_Count), 32'd0);

        // Squash
        step(1'b1, 1'b1, 5'd20, 2'd0, {64'd0, 32'h20}, 1'b1, 5'd9, 32'h99, 1'b1);
        step(1'b1, 1'b1, 5'd21, 2'd0, {64'd0, 32'h21}, 1'b1, 5'd10, 32'hAA, 1'b1);
        step(1'b1, 1'b1, 5'd9, 2'd0, {64'd0, 32'h900}, 1'b0, 5'd0, 32'd0, 1'b0);
        query("sq_hit9", 5'd9, 1'b0);
        query("sq_hit10", 5'd10, 1'b1);
        check("sq_count2", 32'(Side_Count), 32'd2);
        idle();
        check("sq_dead_no_write", 32'(WB_RegWrite), 32'd0);
        check("sq_count1", 32'(Side_Count), 32'd1);
        idle();
        check("sq_write10", 32'(WB_RegWrite), 32'd1);
        check("sq_count0", 32'(Side_Count), 32'd0);
        // Same-cycle side result to the committing register is newer and survives
        step(1'b1, 1'b1, 5'd20, 2'd0, {64'd0, 32'h2000}, 1'b1, 5'd20, 32'h2020, 1'b1);
        query("sq_same_hit", 5'd20, 1'b1);
        idle();
        check("sq_same_we", 32'(WB_RegWrite), 32'd1);

        // Simultaneous accept and pop at full-minus-one, across pointer wrap
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 5'(21 + i), 2'd0, {64'd0, 32'h5000 + 32'(i)},
                 1'b1, 5'(1 + i), $urandom, 1'b1);
        end
        check("wrap_count3", 32'(Side_Count), 32'd3);
        for (int i = 0; i < 3 * FIFO_DEPTH; i++) begin
            step(1'b0, 1'b0, 5'd0, 2'd0, 96'd0, 1'b1, 5'(1 + (i % 31)), $urandom, 1'b1);
            check("wrap_we", 32'(WB_RegWrite), 32'd1);
            check("wrap_count", 32'(Side_Count), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            check("wrap_tail_we", 32'(WB_RegWrite), 32'd1);
        end
        check("wrap_count0", 32'(Side_Count), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 5'(25 + i), 2'd0, {64'd0, 32'h6000 + 32'(i)},
                 1'b1, 5'(1 + i), 32'h600 + 32'(i), 1'b1);
        end
        check("mid_we_pre", 32'(WB_RegWrite), 32'd1);
        check("mid_count_pre", 32'(Side_Count), 32'd3);
        Query_Reg = 5'd2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(WB_RegWrite), 32'd0);
        check("mid_rst_reg", 32'(WB_WriteReg), 32'd0);
        check("mid_rst_data", WB_WriteData, 32'd0);
        check("mid_rst_count", 32'(Side_Count), 32'd0);
        check("mid_rst_ready", 32'(Side_Ready), 32'd1);
        check("mid_rst_hit", 32'(Query_Hit), 32'd0);
        sideQ.delete();
        lastReg  = '0;
        lastData = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("post_rst_no_write", 32'(WB_RegWrite), 32'd0);
        end
        check("post_rst_count", 32'(Side_Count), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
